ctrl_rw_sched: RTL
==================

Name: ctrl_rw_sched

Overview:
Parametrised CAS-to-data timing scheduler for the DDR4 controller, successor to the single-command read/write timer. Each accepted CAS command (RD/WR/RDA/WRA) is queued with its own absolute due timestamp, so up to DEPTH commands can be outstanding. The block pulses the matching data-ready strobe when each command's latency expires, then tracks the data burst. It sits between the command scheduler (cas_rdy source) and the data-path read/write engines.

Parameters:
DEPTH, 8, outstanding-CAS queue entries (power of 2, ≥2)
TW, 6, width of each timing input (CL, CWL, AL, RD_PRE, WR_PRE)
TS_W, 8, timestamp counter width; must satisfy 2*(2^TW-1) < 2^(TS_W-1)
BL, 8, full burst length in beats; a full burst lasts BL/2 cycles

Ports:
CK_t  in  1  controller clock; all logic on the rising edge
reset  in  1  synchronous, active-high
cas_rdy  in  1  one-cycle strobe: a CAS command was issued this cycle
cas_cmd  in  3  cmd_t code of that CAS (RD_R, WR_R, RDA_R, WRA_R)
cas_bc4  in  1  burst-chop-4 for this CAS; the burst lasts 2 cycles
CL, CWL, AL, RD_PRE, WR_PRE  in  TW each  mode-register timings, held static outside reset
rd_rdy, wr_rdy, rda_rdy, wra_rdy  out  1  one-cycle data-ready strobes
burst_active  out  1  high during every data-burst cycle
rw_done  out  1  pulse on the last cycle of each burst
data_idle  out  1  high when the queue is empty and no burst is active
q_level  out  $clog2(DEPTH)+1  current queue occupancy
q_full  out  1  q_level == DEPTH
ovf_err, late_err, overlap_err  out  1  sticky error flags, cleared only by reset

Behaviour:
- Reset values:
  - All strobes, burst_active, rw_done, q_full and the error flags: 0.
  - data_idle: 1. q_level: 0.
  - Timestamp ts: 0. State: IDLE. Queue emptied.
- ts increments every cycle and wraps modulo 2^TS_W.
- Latency calculation:
  - lat = CL+AL-RD_PRE for RD_R/RDA_R.
  - lat = CWL+AL-WR_PRE for WR_R/WRA_R.
  - Computed at TW+2 bits signed; results below 1 clamp to 1.
- Push on cas_rdy:
  - The entry is {cmd, bc4, due = ts + lat mod 2^TS_W}.
  - An unrecognised cas_cmd is ignored: no push, no error.
- A push while full is dropped and sets ovf_err. A simultaneous pop frees a slot, so push+pop when full is legal.
- Head is due when (ts - head.due) mod 2^TS_W < 2^(TS_W-1).
  - If due and ts == due: pop.
  - If due and ts != due: pop and set late_err. This happens when a later command has a shorter latency than an earlier one; the queue stays strictly in order.
- Pop cycle actions:
  - Exactly one strobe matching head.cmd pulses in that cycle.
  - A burst counter loads B-1, where B = 2 if bc4, else BL/2.
  - burst_active is high from the pop cycle for B cycles.
  - rw_done pulses in the final burst cycle.
- Burst overlap:
  - If a pop occurs while the burst counter is nonzero, set overlap_err and restart the counter for the new burst.
  - A pop exactly one cycle after rw_done is seamless and legal.
- FSM states (next state decided combinationally, registered on CK_t):
  - IDLE: queue empty, no burst. On push → WAIT.
  - WAIT: entries queued, no burst. Head due → DATA.
  - DATA: burst active. At the last cycle: → DATA if the head is due the next cycle, else → WAIT if the queue is non-empty, else → IDLE.
- data_idle = (state == IDLE), registered.
- Reset asserted mid-operation: queue is flushed, strobes drop the next cycle, any burst in progress is abandoned with no rw_done.

Decomposition:
- Shared package ctrl_rw_pkg holds:
  - typedef enum logic [2:0] cmd_t: NOP_R=0, RD_R=1, WR_R=2, RDA_R=3, WRA_R=4.
  - typedef enum rw_sched_state_t: IDLE, WAIT, DATA.
  - Queue-entry packed struct {cmd_t cmd; logic bc4; logic [TS_W-1:0] due;}.
- One sub-module, cas_due_fifo: a parametrised synchronous FIFO (DEPTH, entry type) with push/pop/full/empty/level and same-cycle push+pop when full.

Test Plan:
1. Single read: CL=11, AL=0, RD_PRE=1, RD_R at cycle 10 → rd_rdy only at 20; burst_active 20–23; rw_done at 23; data_idle 0 from 11, back to 1 at 24.
2. Back-to-back: WR_R (CWL=9, AL=0, WR_PRE=1, lat 8) at cycles 5 and 9 → wr_rdy at 13 and 17; burst 13–20; no overlap_err; q_level peaks at 2.
3. Overlap and BC4: CL=11, RD_PRE=1, RDA_R bc4 at cycle 0 and RD_R at cycle 1 → rda_rdy at 10 with 2-cycle burst, rd_rdy at 11, overlap_err=1.
4. Late: RD_R (lat 10) at cycle 0, then WR_R (lat 4) at cycle 1 → rd_rdy at 10; wr_rdy at 11 with late_err=1.
5. Overflow: DEPTH=8, nine cas_rdy in consecutive cycles with lat 20 → q_full at the 8th; ovf_err=1; exactly 8 strobes emitted.
6. Wrap/reset: TS_W=8, push at ts=250 with lat 10 → strobe at ts=4; repeat with reset pulsed at ts=252 → no strobe, q_level=0, data_idle=1.

Source files
------------

// File: rtl/ctrl_rw_pkg.sv
// Shared types for the CAS-to-data scheduler: command codes, FSM states and
// the default-width queue entry layout.
package ctrl_rw_pkg;

  typedef enum logic [2:0] {
    NOP_R = 3'd0,
    RD_R  = 3'd1,
    WR_R  = 3'd2,
    RDA_R = 3'd3,
    WRA_R = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DATA = 2'd2
  } rw_sched_state_t;

  localparam int CAS_TS_W = 8;

  typedef struct packed {
    cmd_t                cmd;
    logic                bc4;
    logic [CAS_TS_W-1:0] due;
  } cas_entry_t;

endpackage

// File: rtl/ctrl_rw_sched_cas_due_fifo.sv
// Synchronous FIFO of pending CAS entries; a push is accepted when full if a
// pop happens in the same cycle.
module cas_due_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  T                       i_push_data,
  input  logic                   i_pop,
  output T                       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_level = r_level;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/ctrl_rw_sched.sv
// CAS-to-data scheduler: queues each CAS with an absolute due timestamp,
// strobes data-ready when it falls due and tracks the resulting data burst.
module ctrl_rw_sched #(
  parameter int DEPTH = 8,
  parameter int TW    = 6,
  parameter int TS_W  = 8,
  parameter int BL    = 8
) (
  input  logic                     CK_t,
  input  logic                     reset,
  input  logic                     cas_rdy,
  input  logic [2:0]               cas_cmd,
  input  logic                     cas_bc4,
  input  logic [TW-1:0]            CL,
  input  logic [TW-1:0]            CWL,
  input  logic [TW-1:0]            AL,
  input  logic [TW-1:0]            RD_PRE,
  input  logic [TW-1:0]            WR_PRE,
  output logic                     rd_rdy,
  output logic                     wr_rdy,
  output logic                     rda_rdy,
  output logic                     wra_rdy,
  output logic                     burst_active,
  output logic                     rw_done,
  output logic                     data_idle,
  output logic [$clog2(DEPTH):0]   q_level,
  output logic                     q_full,
  output logic                     ovf_err,
  output logic                     late_err,
  output logic                     overlap_err
);
  import ctrl_rw_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BL);

  // Same layout as cas_entry_t, with the timestamp width following TS_W.
  typedef struct packed {
    cmd_t            cmd;
    logic            bc4;
    logic [TS_W-1:0] due;
  } entry_t;

  logic [TS_W-1:0]   r_ts;
  rw_sched_state_t   r_state;
  rw_sched_state_t   w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic              r_data_idle;
  logic              r_ovf, r_late, r_ovl;

  entry_t            w_push_entry;
  entry_t            w_head;
  logic              w_full, w_empty;
  logic [LW-1:0]     w_level;
  logic              w_push_req, w_is_rd, w_pop, w_due_nxt;
  logic [TS_W-1:0]   w_age, w_age_nxt;
  logic signed [TW+1:0] w_lat, w_lat_c;

  assign w_push_req = cas_rdy && (cas_cmd == RD_R || cas_cmd == WR_R ||
                                  cas_cmd == RDA_R || cas_cmd == WRA_R);
  assign w_is_rd    = (cas_cmd == RD_R) || (cas_cmd == RDA_R);

  always_comb begin
    if (w_is_rd)
      w_lat = $signed({2'b00, CL}) + $signed({2'b00, AL}) - $signed({2'b00, RD_PRE});
    else
      w_lat = $signed({2'b00, CWL}) + $signed({2'b00, AL}) - $signed({2'b00, WR_PRE});
    w_lat_c = (w_lat < 1) ? (TW+2)'(1) : w_lat;
  end

  assign w_push_entry.cmd = cmd_t'(cas_cmd);
  assign w_push_entry.bc4 = cas_bc4;
  assign w_push_entry.due = r_ts + TS_W'($unsigned(w_lat_c));

  cas_due_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .i_clk       (CK_t),
    .i_rst       (reset),
    .i_push      (w_push_req),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level)
  );

  // Modular age: MSB clear means the head's due time has arrived or passed.
  assign w_age     = r_ts - w_head.due;
  assign w_age_nxt = w_age + TS_W'(1);
  assign w_pop     = !w_empty && !w_age[TS_W-1];
  assign w_due_nxt = !w_empty && !w_age_nxt[TS_W-1];

  always_comb begin
    w_state_nxt = IDLE;
    if (w_pop || (r_cnt > CW'(1)) || (r_cnt == CW'(1) && w_due_nxt))
      w_state_nxt = DATA;
    else if (!w_empty || w_push_req)
      w_state_nxt = WAIT;
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      r_ts        <= '0;
      r_state     <= IDLE;
      r_data_idle <= 1'b1;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_late      <= 1'b0;
      r_ovl       <= 1'b0;
    end else begin
      r_ts        <= r_ts + TS_W'(1);
      r_state     <= w_state_nxt;
      r_data_idle <= (w_state_nxt == IDLE);
      if (w_pop) begin
        r_cnt <= w_head.bc4 ? CW'(1) : CW'(BL/2 - 1);
        if (r_cnt != '0)     r_ovl  <= 1'b1;
        if (w_age != '0)     r_late <= 1'b1;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign rd_rdy       = w_pop && (w_head.cmd == RD_R);
  assign wr_rdy       = w_pop && (w_head.cmd == WR_R);
  assign rda_rdy      = w_pop && (w_head.cmd == RDA_R);
  assign wra_rdy      = w_pop && (w_head.cmd == WRA_R);
  assign burst_active = w_pop || (r_cnt != '0);
  assign rw_done      = (r_cnt == CW'(1)) && !w_pop;
  assign data_idle    = r_data_idle;
  assign q_level      = w_level;
  assign q_full       = w_full;
  assign ovf_err      = r_ovf;
  assign late_err     = r_late;
  assign overlap_err  = r_ovl;

endmodule
